// File: rtl/uart_boot_loader_p_if.sv
// RAM-side bus of the UART boot loader: the loader drives strobe, direction, address
// and write data; the RAM returns read data one cycle after a read strobe.
interface uart_boot_loader_p_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  ram_enable;
  logic                  ram_rw;
  logic [ADDR_WIDTH-1:0] ram_adr;
  logic [DATA_WIDTH-1:0] ram_in;
  logic [DATA_WIDTH-1:0] ram_out;

  modport master (
    output ram_enable, ram_rw, ram_adr, ram_in,
    input  ram_out
  );

  modport slave (
    input  ram_enable, ram_rw, ram_adr, ram_in,
    output ram_out
  );
endinterface

// File: rtl/uart_boot_loader_p.sv
// UART boot loader: receives a memory image over rx, packs bytes into RAM words and
// writes them sequentially; in run mode a scan_memory edge dumps the RAM out over tx.
module uart_boot_loader_p #(
  parameter int CLK_DIV    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_BYTES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 rx,
  input  logic                 scan_memory,
  output logic                 tx,
  output logic                 boot,
  output logic                 frame_err,
  uart_boot_loader_p_if.master ram
);
  localparam int DATA_WIDTH = 8 * WORD_BYTES;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_READ, TX_LATCH, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // synchronisers and edge detectors
  logic rx_s1, rx_s2, rx_d;
  logic sc_s1, sc_s2, sc_d;
  logic rx_fall, scan_rise;

  assign rx_fall   = rx_d & ~rx_s2;
  assign scan_rise = sc_s2 & ~sc_d;

  // receiver
  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_bit, rx_bit_nx;
  logic [7:0]    rx_shift, rx_shift_nx;
  logic          byte_ok, byte_bad;

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + 1'b1;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    byte_ok     = 1'b0;
    byte_bad    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_fall) rx_state_nx = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
          rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
          else                rx_bit_nx   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx   = '0;
          byte_ok     = rx_s2;
          byte_bad    = ~rx_s2;
          rx_state_nx = RX_IDLE;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (ce) begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  // loader / scanner
  tx_state_t             tx_state, tx_state_nx;
  logic [CW-1:0]         tx_cnt, tx_cnt_nx;
  logic [2:0]            tx_bit, tx_bit_nx;
  logic [BW-1:0]         tx_byte, tx_byte_nx;
  logic [DATA_WIDTH-1:0] tx_word, tx_word_nx;
  logic [BW-1:0]         byte_cnt, byte_cnt_nx;
  logic [DATA_WIDTH-1:0] asm_word, asm_word_nx, merged;
  logic                  tx_nx, boot_nx, frame_err_nx;
  logic                  ram_enable_nx, ram_rw_nx;
  logic [ADDR_WIDTH-1:0] ram_adr_nx;
  logic [DATA_WIDTH-1:0] ram_in_nx;

  always_comb begin
    tx_state_nx   = tx_state;
    tx_cnt_nx     = tx_cnt + 1'b1;
    tx_bit_nx     = tx_bit;
    tx_byte_nx    = tx_byte;
    tx_word_nx    = tx_word;
    tx_nx         = tx;
    byte_cnt_nx   = byte_cnt;
    asm_word_nx   = asm_word;
    boot_nx       = boot;
    frame_err_nx  = frame_err | byte_bad;
    // every strobe, read or write, lives exactly one enabled cycle
    ram_enable_nx = 1'b0;
    ram_rw_nx     = 1'b0;
    ram_adr_nx    = ram.ram_adr;
    ram_in_nx     = ram.ram_in;

    merged = asm_word;
    for (int unsigned i = 0; i < WORD_BYTES; i++)
      if (byte_cnt == BW'(i)) merged[i*8 +: 8] = rx_shift;

    if (ram.ram_enable && ram.ram_rw) begin
      ram_adr_nx = ram.ram_adr + 1'b1;
      if (ram.ram_adr == '1) boot_nx = 1'b0;
    end

    if (byte_ok && boot) begin
      asm_word_nx = merged;
      if (byte_cnt == BYTE_LAST) begin
        byte_cnt_nx   = '0;
        ram_in_nx     = merged;
        ram_enable_nx = 1'b1;
        ram_rw_nx     = 1'b1;
      end else begin
        byte_cnt_nx = byte_cnt + 1'b1;
      end
    end

    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nx = '0;
        if (scan_rise && !boot) begin
          ram_enable_nx = 1'b1;
          tx_state_nx   = TX_READ;
        end
      end
      TX_READ: tx_state_nx = TX_LATCH;
      TX_LATCH: begin
        tx_word_nx  = ram.ram_out;
        tx_nx       = 1'b0;
        tx_cnt_nx   = '0;
        tx_byte_nx  = '0;
        tx_state_nx = TX_START;
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_nx       = tx_word[0];
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        // the word shifts right one bit per data bit, so the next byte lands in [7:0]
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx  = '0;
          tx_word_nx = tx_word >> 1;
          if (tx_bit == 3'd7) begin
            tx_nx       = 1'b1;
            tx_state_nx = TX_STOP;
          end else begin
            tx_bit_nx = tx_bit + 3'd1;
            tx_nx     = tx_word[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx = '0;
          if (tx_byte != BYTE_LAST) begin
            tx_byte_nx  = tx_byte + 1'b1;
            tx_nx       = 1'b0;
            tx_state_nx = TX_START;
          end else if (ram.ram_adr == '1) begin
            ram_adr_nx  = '0;
            tx_state_nx = TX_IDLE;
          end else begin
            ram_adr_nx    = ram.ram_adr + 1'b1;
            ram_enable_nx = 1'b1;
            tx_state_nx   = TX_READ;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1          <= 1'b0;
      rx_s2          <= 1'b0;
      rx_d           <= 1'b0;
      sc_s1          <= 1'b0;
      sc_s2          <= 1'b0;
      sc_d           <= 1'b0;
      tx_state       <= TX_IDLE;
      tx_cnt         <= '0;
      tx_bit         <= '0;
      tx_byte        <= '0;
      tx_word        <= '0;
      byte_cnt       <= '0;
      asm_word       <= '0;
      tx             <= 1'b1;
      boot           <= 1'b1;
      frame_err      <= 1'b0;
      ram.ram_enable <= 1'b0;
      ram.ram_rw     <= 1'b0;
      ram.ram_adr    <= '0;
      ram.ram_in     <= '0;
    end else if (ce) begin
      rx_s1          <= rx;
      rx_s2          <= rx_s1;
      rx_d           <= rx_s2;
      sc_s1          <= scan_memory;
      sc_s2          <= sc_s1;
      sc_d           <= sc_s2;
      tx_state       <= tx_state_nx;
      tx_cnt         <= tx_cnt_nx;
      tx_bit         <= tx_bit_nx;
      tx_byte        <= tx_byte_nx;
      tx_word        <= tx_word_nx;
      byte_cnt       <= byte_cnt_nx;
      asm_word       <= asm_word_nx;
      tx             <= tx_nx;
      boot           <= boot_nx;
      frame_err      <= frame_err_nx;
      ram.ram_enable <= ram_enable_nx;
      ram.ram_rw     <= ram_rw_nx;
      ram.ram_adr    <= ram_adr_nx;
      ram.ram_in     <= ram_in_nx;
    end
  end
endmodule

// File: tb/tb_uart_boot_loader_p.sv
// Testbench for uart_boot_loader_p: 2-byte words, 4-word RAM, 16 clocks per bit.
module tb_uart_boot_loader_p;
  localparam int CLK_DIV    = 16;
  localparam int ADDR_WIDTH = 2;
  localparam int WORD_BYTES = 2;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 4;

  typedef struct packed {
    logic [1:0]  adr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  b;
    bit          freeze;
    bit          wr;
    logic [1:0]  adr;
    logic [15:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic rx = 1'b1;
  logic scan_memory = 1'b0;
  logic tx, boot, frame_err;

  int n_checks = 0;
  int n_fail = 0;

  wr_t        wr_q[$];
  wr_t        wr_exp;
  logic [7:0] tx_q[$];
  bit         tx_busy = 1'b0;
  bit         boot_due = 1'b0;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  uart_boot_loader_p_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) ram_if ();

  uart_boot_loader_p #(
    .CLK_DIV(CLK_DIV),
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_BYTES(WORD_BYTES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .rx(rx),
    .scan_memory(scan_memory),
    .tx(tx),
    .boot(boot),
    .frame_err(frame_err),
    .ram(ram_if)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, read data valid the cycle after a read strobe
  always @(posedge clk) begin
    if (ce && ram_if.ram_enable) begin
      if (ram_if.ram_rw) mem[ram_if.ram_adr] <= ram_if.ram_in;
      else               ram_if.ram_out <= mem[ram_if.ram_adr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // write scoreboard; a strobe held over two enabled cycles shows up as an extra write
  always @(negedge clk) begin
    if (boot_due) begin
      chk("boot_after_last_write", boot, 1'b0);
      boot_due = 1'b0;
    end
    if (rst_n && ce && ram_if.ram_enable && ram_if.ram_rw) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got adr %0d data 0x%0h, expected no write at %0t",
                 ram_if.ram_adr, ram_if.ram_in, $time);
      end else begin
        wr_exp = wr_q.pop_front();
        chk("write_adr", ram_if.ram_adr, wr_exp.adr);
        chk("write_data", ram_if.ram_in, wr_exp.data);
        if (wr_exp.adr == 2'(DEPTH - 1)) begin
          chk("boot_during_last_write", boot, 1'b1);
          boot_due = 1'b1;
        end
      end
    end
    if (rst_n && ce && ram_if.ram_enable && !ram_if.ram_rw && boot) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_in_load: got read strobe at adr %0d, expected none while boot=1 at %0t",
               ram_if.ram_adr, $time);
    end
  end

  // tx checker: every cycle of each frame is compared against the ideal waveform
  initial begin : tx_mon
    logic       prev;
    logic [7:0] e;
    logic       expb;
    int         k;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && !boot && prev && !tx) begin
        tx_busy = 1'b1;
        if (tx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx_frame: got start bit, expected idle at %0t", $time);
          e = 8'h00;
        end else begin
          e = tx_q.pop_front();
        end
        for (int c = 0; c < 10 * CLK_DIV; c++) begin
          if (c > 0) @(negedge clk);
          k = c / CLK_DIV;
          expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e[k-1];
          chk("tx_bit", tx, expb);
        end
        tx_busy = 1'b0;
      end
      prev = tx;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit freeze);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = frame[k];
      if (freeze && k == 4) begin
        cycles(CLK_DIV / 2);
        ce = 1'b0;
        cycles(50);
        ce = 1'b1;
        cycles(CLK_DIV - CLK_DIV / 2);
      end else begin
        cycles(CLK_DIV);
      end
    end
    rx = 1'b1;
    cycles(4);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx"}, tx, 1'b1);
    chk({tag, "_boot"}, boot, 1'b1);
    chk({tag, "_ram_enable"}, ram_if.ram_enable, 1'b0);
    chk({tag, "_ram_rw"}, ram_if.ram_rw, 1'b0);
    chk({tag, "_ram_adr"}, ram_if.ram_adr, '0);
    chk({tag, "_ram_in"}, ram_if.ram_in, '0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  initial begin
    vec_t vecs[8];
    int   t;
    vecs[0] = '{8'h11, 1'b0, 1'b0, 2'd0, 16'h0000};
    vecs[1] = '{8'h22, 1'b0, 1'b1, 2'd0, 16'h2211};
    vecs[2] = '{8'h33, 1'b1, 1'b0, 2'd0, 16'h0000};
    vecs[3] = '{8'h44, 1'b0, 1'b1, 2'd1, 16'h4433};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 2'd0, 16'h0000};
    vecs[5] = '{8'h66, 1'b0, 1'b1, 2'd2, 16'h6655};
    vecs[6] = '{8'h77, 1'b0, 1'b0, 2'd0, 16'h0000};
    vecs[7] = '{8'h88, 1'b0, 1'b1, 2'd3, 16'h8877};

    rst_n = 1'b0;
    cycles(3);
    check_reset("por");
    rst_n = 1'b1;
    cycles(4);

    // 3-cycle low glitch must be rejected as a false start
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(40);
    chk("glitch_frame_err", frame_err, 1'b0);

    // bad stop bit: byte dropped, flag set, next good bytes form word 0
    send_byte(8'hA5, 1'b0, 1'b0);
    chk("frame_err_set", frame_err, 1'b1);
    send_byte(8'h5A, 1'b1, 1'b0);
    wr_q.push_back('{2'd0, 16'h3C5A});
    send_byte(8'h3C, 1'b1, 1'b0);
    chk("frame_adr_after_write", ram_if.ram_adr, 2'd1);
    send_byte(8'h77, 1'b1, 1'b0);

    // asynchronous reset mid-load, checked away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_load");
    cycles(3);
    rst_n = 1'b1;
    cycles(4);

    // scan requests are ignored while loading
    scan_memory = 1'b1;
    cycles(4);
    scan_memory = 1'b0;
    cycles(10);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) wr_q.push_back('{vecs[i].adr, vecs[i].word});
      send_byte(vecs[i].b, 1'b1, vecs[i].freeze);
    end
    cycles(2);
    chk("boot_run_mode", boot, 1'b0);
    chk("writes_drained", wr_q.size(), 0);
    chk("load_frame_err", frame_err, 1'b0);
    chk("load_adr_wrapped", ram_if.ram_adr, 2'd0);

    // scan: dump all words, with a second request mid-scan that must be ignored
    for (int i = 0; i < 8; i++) tx_q.push_back(vecs[i].b);
    scan_memory = 1'b1;
    cycles(3);
    scan_memory = 1'b0;
    cycles(300);
    scan_memory = 1'b1;
    cycles(3);
    scan_memory = 1'b0;
    t = 0;
    while ((tx_q.size() != 0 || tx_busy) && t < 4000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("scan_complete", (tx_q.size() == 0 && !tx_busy), 1'b1);
    cycles(5);
    chk("scan_tx_idle", tx, 1'b1);
    chk("scan_adr_zero", ram_if.ram_adr, 2'd0);
    chk("scan_no_strobe", ram_if.ram_enable, 1'b0);

    // run mode: bytes are checked but never written
    send_byte(8'h99, 1'b1, 1'b0);
    chk("run_frame_err_clear", frame_err, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    chk("run_frame_err_set", frame_err, 1'b1);
    chk("run_adr_hold", ram_if.ram_adr, 2'd0);
    chk("run_boot_low", boot, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
